// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, word-length encodings and oversample tick limits.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam logic [3:0] TICKS_16 = 4'd15;
    localparam logic [3:0] TICKS_13 = 4'd12;

    // Index of the final data bit for a word length code (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_index(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    function automatic logic [3:0] tick_limit(input logic osm_sel);
        return osm_sel ? TICKS_13 : TICKS_16;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake of the UART transmitter: one word per accepted tx_start.
interface uart_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Oversample tick counter producing a bit_end strobe every 16 or 13 enabled baud ticks.
// Held at zero while not running so each frame starts on a clean bit boundary.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic baud_clk,
    input  logic bge,
    input  logic osm_sel,
    input  logic run,
    output logic bit_end
);

    logic [3:0] tick_cnt;
    logic       tick_en;

    assign tick_en = run && baud_clk && bge;
    assign bit_end = tick_en && (tick_cnt == tick_limit(osm_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 4'd0;
        end else if (!run) begin
            tick_cnt <= 4'd0;
        end else if (tick_en) begin
            tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
// Frame format is latched at accept so mid-frame changes on the control inputs are harmless.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_clk,
    input  logic       PEN,
    input  logic       STB,
    input  logic       BGE,
    input  logic       OSM_SEL,
    input  logic [1:0] WLS,
    uart_tx_if.slave   tx_if,
    output logic       UART_TX_O
);

    uart_state_t state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic        parity_acc;
    logic        stop_cnt;
    logic        pen_q;
    logic        stb_q;
    logic        osm_q;
    logic [1:0]  wls_q;
    logic        bit_end;

    uart_bit_timer u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .bge      (BGE),
        .osm_sel  (osm_q),
        .run      (state != IDLE),
        .bit_end  (bit_end)
    );

    // The line level for the next bit is computed at the current bit's end, keeping UART_TX_O registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shift_reg     <= 8'd0;
            bit_idx       <= 3'd0;
            parity_acc    <= 1'b0;
            stop_cnt      <= 1'b0;
            pen_q         <= 1'b0;
            stb_q         <= 1'b0;
            osm_q         <= 1'b0;
            wls_q         <= WLS_8;
            UART_TX_O     <= 1'b1;
            tx_if.tx_busy <= 1'b0;
            tx_if.tx_done <= 1'b0;
        end else begin
            tx_if.tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_if.tx_start) begin
                        shift_reg     <= tx_if.tx_data;
                        pen_q         <= PEN;
                        stb_q         <= STB;
                        osm_q         <= OSM_SEL;
                        wls_q         <= WLS;
                        bit_idx       <= 3'd0;
                        parity_acc    <= 1'b0;
                        stop_cnt      <= 1'b0;
                        UART_TX_O     <= 1'b0;
                        tx_if.tx_busy <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        UART_TX_O <= shift_reg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        parity_acc <= parity_acc ^ shift_reg[0];
                        shift_reg  <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == last_bit_index(wls_q)) begin
                            if (pen_q) begin
                                UART_TX_O <= parity_acc ^ shift_reg[0];
                                state     <= PARITY;
                            end else begin
                                UART_TX_O <= 1'b1;
                                state     <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            UART_TX_O <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        UART_TX_O <= 1'b1;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stb_q && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx_if.tx_busy <= 1'b0;
                            tx_if.tx_done <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: begin
                    UART_TX_O     <= 1'b1;
                    tx_if.tx_busy <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
